// File: rtl/vote_session_ctrl.sv
// Voting session controller: arms one ballot, arbitrates simultaneous vote pulses,
// keeps saturating tallies, enforces a post-vote lockout and serves tallies in result mode.
module vote_session_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int SEL_W       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] vote_valid,
  input  logic [SEL_W-1:0]    result_sel,
  output logic                ballot_ready,
  output logic                vote_ack,
  output logic [SEL_W-1:0]    vote_cand,
  output logic [NUM_CAND-1:0] cand_led,
  output logic [CNT_W-1:0]    result_count,
  output logic [CNT_W-1:0]    total_votes,
  output logic                sat_flag
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RECORD  = 3'd2,
    LOCKOUT = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [SEL_W-1:0]        idx_reg, idx_next;
  logic [LOCK_W-1:0]       lock_reg;
  logic [CNT_W-1:0]        total_reg;
  logic                    sat_reg;
  logic [CNT_W-1:0]        result_reg;
  logic [CNT_W-1:0]        total_out_reg;
  logic [NUM_CAND*CNT_W-1:0] tally_flat;
  logic [NUM_CAND-1:0]     tally_hit;
  logic [NUM_CAND-1:0]     tally_full;
  logic                    any_vote;
  logic [SEL_W-1:0]        win_idx;
  logic [CNT_W-1:0]        sel_count;
  logic                    record;
  logic                    total_full;

  assign record     = (state_reg == RECORD);
  assign total_full = &total_reg;

  // Lowest-index pending vote wins; scanning downward leaves the smallest index last.
  always_comb begin
    win_idx  = '0;
    any_vote = |vote_valid;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (vote_valid[i]) win_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (mode)            state_next = RESULT;
        else if (ballot_arm) state_next = ARMED;
      end
      ARMED: begin
        if (mode) begin
          state_next = RESULT;
        end else if (any_vote) begin
          state_next = RECORD;
          idx_next   = win_idx;
        end
      end
      RECORD:  state_next = LOCKOUT;
      LOCKOUT: if (lock_reg == '0) state_next = IDLE;
      RESULT:  if (!mode) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                                lock_reg <= '0;
    else if (record)                          lock_reg <= LOCK_W'(LOCK_CYCLES - 1);
    else if (state_reg == LOCKOUT && lock_reg != '0) lock_reg <= lock_reg - 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_tally
      logic [CNT_W-1:0] cnt_reg;
      assign tally_hit[gi]  = record && (idx_reg == SEL_W'(gi));
      assign tally_full[gi] = &cnt_reg;
      assign tally_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      always_ff @(posedge clock) begin
        if (reset)                              cnt_reg <= '0;
        else if (tally_hit[gi] && !tally_full[gi]) cnt_reg <= cnt_reg + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      total_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      if (record && !total_full) total_reg <= total_reg + 1'b1;
      if ((|(tally_hit & tally_full)) || (record && total_full)) sat_reg <= 1'b1;
    end
  end

  // Out-of-range selections fall through every compare and read back as zero.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (32'(result_sel) == i) sel_count = tally_flat[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state_reg != RESULT || !mode) begin
      result_reg    <= '0;
      total_out_reg <= '0;
    end else begin
      result_reg    <= sel_count;
      total_out_reg <= total_reg;
    end
  end

  assign ballot_ready = (state_reg == ARMED);
  assign vote_ack     = record;
  assign vote_cand    = idx_reg;
  assign cand_led     = (state_reg == LOCKOUT) ? (NUM_CAND'(1) << idx_reg) : '0;
  assign result_count = result_reg;
  assign total_votes  = total_out_reg;
  assign sat_flag     = sat_reg;

endmodule
